// File: rtl/lock_policy_controller.sv
// lock_policy_controller: sequencing/configuration controller for the 4-bit lock core.
// It relocks the core after an unlock hold time and releases lockouts after an
// escalating timeout. It also owns the unlock code, which is reprogrammed through a
// two-entry confirm sequence.
// Optional build macro: LOCK_AUDIT_EN adds audit_count[7:0], a saturating count of
// lockout entries that only reset clears.
module lock_policy_controller #(
  parameter logic [3:0] DEFAULT_CODE = 4'b1010,
  parameter int         HOLD_CYCLES  = 8,
  parameter int         LOCKOUT_BASE = 16,
  parameter int         MAX_ESC      = 3,
  parameter int         PROG_TIMEOUT = 32,
  parameter int         TIMER_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         admin_reset,
  input  logic         enter,
  input  logic [3:0]   code_in,
  input  logic         prog_en,
  input  logic         core_unlock,
  input  logic         core_lockout,
  output logic [3:0]   lock_code,
  output logic         core_relock,
  output logic         core_clear,
  output logic         prog_ok,
  output logic         prog_err,
  output logic [1:0]   esc_level,
  output logic         busy
`ifdef LOCK_AUDIT_EN
  ,
  output logic [7:0]   audit_count
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, LOCKOUT, PROG_CONFIRM} state_t;

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [1:0]           esc_n;
  logic [3:0]           code_n, first_code, first_n;
  logic                 relock_n, clear_n, ok_n, err_n;

  logic enter_s1, enter_s2, enter_d, enter_p;
  logic unlock_q, lockout_q, unlock_rise, lockout_rise;
  logic admin_q;

  // Button synchronizer and registered one-shot. A held button gives a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      enter_d  <= 1'b0;
      enter_p  <= 1'b0;
    end else begin
      enter_s1 <= enter;
      enter_s2 <= enter_s1;
      enter_d  <= enter_s2;
      enter_p  <= enter_s2 & ~enter_d;
    end
  end

  // Registered edge detect on the core status lines and on admin_reset.
  // These signals are in the same clock domain, so no synchronizer is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unlock_q     <= 1'b0;
      lockout_q    <= 1'b0;
      unlock_rise  <= 1'b0;
      lockout_rise <= 1'b0;
      admin_q      <= 1'b0;
    end else begin
      unlock_q     <= core_unlock;
      lockout_q    <= core_lockout;
      unlock_rise  <= core_unlock & ~unlock_q;
      lockout_rise <= core_lockout & ~lockout_q;
      admin_q      <= admin_reset;
    end
  end

  // Next-state, timer, escalation, code and pulse decode.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    esc_n    = esc_level;
    code_n   = lock_code;
    first_n  = first_code;
    relock_n = 1'b0;
    clear_n  = 1'b0;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    if (admin_reset) begin
      // The admin override wins over everything. Only its rising edge clears the core.
      state_n = IDLE;
      timer_n = '0;
      esc_n   = '0;
      clear_n = ~admin_q;
    end else begin
      case (state)
        IDLE: begin
          // Lockout outranks unlock when both rise in the same cycle.
          if (lockout_rise) begin
            state_n = LOCKOUT;
            timer_n = (TIMER_W'(LOCKOUT_BASE) << esc_level) - TIMER_W'(1);
            if (esc_level != 2'(MAX_ESC)) esc_n = esc_level + 2'd1;
          end else if (unlock_rise) begin
            state_n = HOLD;
            timer_n = TIMER_W'(HOLD_CYCLES - 1);
            esc_n   = '0;
          end else if (prog_en && enter_p) begin
            state_n = PROG_CONFIRM;
            first_n = code_in;
            timer_n = TIMER_W'(PROG_TIMEOUT - 1);
          end
        end
        HOLD: begin
          if (timer == '0 || enter_p) begin
            relock_n = 1'b1;
            state_n  = IDLE;
          end else if (!core_unlock) begin
            state_n = IDLE;
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            clear_n = 1'b1;
            state_n = IDLE;
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
        PROG_CONFIRM: begin
          if (enter_p) begin
            state_n = IDLE;
            if (code_in == first_code) begin
              code_n = code_in;
              ok_n   = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else if (timer == '0) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (!prog_en) begin
            state_n = IDLE;
          end else begin
            timer_n = timer - TIMER_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, timer, configuration and registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      esc_level   <= '0;
      lock_code   <= DEFAULT_CODE;
      first_code  <= '0;
      core_relock <= 1'b0;
      core_clear  <= 1'b0;
      prog_ok     <= 1'b0;
      prog_err    <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      esc_level   <= esc_n;
      lock_code   <= code_n;
      first_code  <= first_n;
      core_relock <= relock_n;
      core_clear  <= clear_n;
      prog_ok     <= ok_n;
      prog_err    <= err_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef LOCK_AUDIT_EN
  // Count lockout entries, saturating at 255. admin_reset does not clear this count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      audit_count <= '0;
    else if (!admin_reset && state == IDLE && lockout_rise && audit_count != 8'hFF)
      audit_count <= audit_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_lock_policy_controller.sv
// Self-checking bench for lock_policy_controller. It mixes directed steps with
// randomized hold/lockout/programming operations, all checked against a small
// reference model: expected code, escalation level and durations.
module tb_lock_policy_controller;

  localparam int HOLD = 8, BASE = 16, MAXE = 3, PTO = 32;

  logic clk = 1'b0, reset = 1'b1, admin_reset = 1'b0, enter = 1'b0;
  logic [3:0] code_in = 4'd0;
  logic prog_en = 1'b0, core_unlock = 1'b0, core_lockout = 1'b0;
  logic [3:0] lock_code;
  logic core_relock, core_clear, prog_ok, prog_err, busy;
  logic [1:0] esc_level;
`ifdef LOCK_AUDIT_EN
  logic [7:0] audit_count;
`endif

  lock_policy_controller dut (
    .clk(clk), .reset(reset), .admin_reset(admin_reset), .enter(enter),
    .code_in(code_in), .prog_en(prog_en), .core_unlock(core_unlock),
    .core_lockout(core_lockout), .lock_code(lock_code), .core_relock(core_relock),
    .core_clear(core_clear), .prog_ok(prog_ok), .prog_err(prog_err),
    .esc_level(esc_level), .busy(busy)
`ifdef LOCK_AUDIT_EN
    , .audit_count(audit_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int relock_cnt = 0, clear_cnt = 0, ok_cnt = 0, err_cnt = 0;

  // Reference model state.
  int m_esc = 0;
  logic [3:0] m_code = 4'b1010;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (core_relock === 1'b1) relock_cnt++;
    if (core_clear  === 1'b1) clear_cnt++;
    if (prog_ok     === 1'b1) ok_cnt++;
    if (prog_err    === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 20 && busy !== 1'b1; i++) step();
    chk(tag, busy, 1);
  endtask

  // Count edges until the selected pulse is seen: 0 relock, 1 clear, 2 ok, 3 err.
  task automatic measure(input int sel, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      step();
      s = (sel == 0) ? core_relock : (sel == 1) ? core_clear : (sel == 2) ? prog_ok : prog_err;
      if (s === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic press(input logic [3:0] c);
    code_in = c;
    enter = 1'b1;
    repeat ($urandom_range(3, 8)) step();
    enter = 1'b0;
    repeat (6) step();
  endtask

  task automatic do_hold(input bit early);
    int n, r0;
    r0 = relock_cnt;
    core_unlock = 1'b1;
    wait_busy("hold_entry");
    m_esc = 0;
    chk("hold_esc", esc_level, m_esc);
    if (!early) begin
      measure(0, n);
      chk("hold_relock_latency", n, HOLD);
      core_unlock = 1'b0;
      step();
      chk("hold_idle", busy, 0);
      chk("hold_single_relock", relock_cnt - r0, 1);
    end else begin
      repeat ($urandom_range(1, 5)) step();
      core_unlock = 1'b0;
      step();
      chk("hold_early_idle", busy, 0);
      repeat (HOLD + 2) step();
      chk("hold_early_no_relock", relock_cnt - r0, 0);
    end
  endtask

  task automatic do_lockout();
    int n, dur;
    core_lockout = 1'b1;
    wait_busy("lockout_entry");
    dur = BASE << m_esc;
    m_esc = (m_esc < MAXE) ? m_esc + 1 : MAXE;
    chk("lockout_esc", esc_level, m_esc);
    measure(1, n);
    chk("lockout_clear_latency", n, dur);
    core_lockout = 1'b0;
    step();
    chk("lockout_idle", busy, 0);
    step();
  endtask

  task automatic do_prog(input logic [3:0] a, input logic [3:0] b);
    int o0, e0;
    o0 = ok_cnt;
    e0 = err_cnt;
    prog_en = 1'b1;
    press(a);
    chk("prog_confirm_wait", busy, 1);
    press(b);
    if (a == b) m_code = b;
    chk("prog_ok_count", ok_cnt - o0, (a == b) ? 1 : 0);
    chk("prog_err_count", err_cnt - e0, (a == b) ? 0 : 1);
    chk("prog_code", lock_code, m_code);
    chk("prog_idle", busy, 0);
    prog_en = 1'b0;
    step();
  endtask

  initial begin
    int n, dur, c0, r0, op;
    logic [3:0] a, b;

    // Reset values.
    repeat (3) step();
    chk("rst_code", lock_code, 4'b1010);
    chk("rst_busy", busy, 0);
    chk("rst_esc", esc_level, 0);
    chk("rst_pulses", {core_relock, core_clear, prog_ok, prog_err}, 0);
    @(negedge clk) reset = 1'b0;
    step();

    // Directed: hold, then four escalating lockouts.
    do_hold(1'b0);
    repeat (4) do_lockout();

    // Directed programming: accept, then mismatch.
    do_prog(4'b0110, 4'b0110);
    do_prog(4'b0110, 4'b0111);

    // Programming timeout with the button held (only one pulse is expected).
    c0 = err_cnt;
    prog_en = 1'b1;
    code_in = 4'b0011;
    enter = 1'b1;
    wait_busy("timeout_entry");
    measure(3, n);
    chk("prog_timeout_latency", n, PTO);
    step();
    chk("prog_timeout_idle", busy, 0);
    chk("prog_timeout_code", lock_code, m_code);
    enter = 1'b0;
    prog_en = 1'b0;
    repeat (6) step();
    chk("prog_timeout_single_err", err_cnt - c0, 1);

    // Randomized operations against the model.
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) do_hold($urandom_range(0, 1) == 1);
      else if (op == 1) do_lockout();
      else begin
        a = 4'($urandom_range(0, 15));
        b = ($urandom_range(0, 1) == 1) ? a : (a ^ 4'($urandom_range(1, 15)));
        do_prog(a, b);
      end
    end

    // Admin override mid-lockout, with the timer at 20.
    if (m_esc == 0) do_lockout();
    c0 = clear_cnt;
    core_lockout = 1'b1;
    wait_busy("admin_lockout_entry");
    dur = BASE << m_esc;
    m_esc = (m_esc < MAXE) ? m_esc + 1 : MAXE;
    repeat (dur - 1 - 20) step();
    admin_reset = 1'b1;
    step();
    m_esc = 0;
    chk("admin_clear_pulse", core_clear, 1);
    chk("admin_esc", esc_level, 0);
    chk("admin_busy", busy, 0);
    step();
    chk("admin_clear_once", core_clear, 0);
    admin_reset = 1'b0;
    core_lockout = 1'b0;
    repeat (3) step();
    chk("admin_clear_count", clear_cnt - c0, 1);
    chk("admin_code_kept", lock_code, m_code);

    // Simultaneous unlock and lockout rise: lockout wins.
    r0 = relock_cnt;
    core_unlock = 1'b1;
    core_lockout = 1'b1;
    wait_busy("simul_entry");
    dur = BASE << m_esc;
    m_esc = (m_esc < MAXE) ? m_esc + 1 : MAXE;
    chk("simul_esc", esc_level, m_esc);
    measure(1, n);
    chk("simul_clear_latency", n, dur);
    chk("simul_no_relock", relock_cnt - r0, 0);
    core_unlock = 1'b0;
    core_lockout = 1'b0;
    repeat (2) step();

    // Asynchronous reset in the middle of a lockout.
    c0 = clear_cnt;
    core_lockout = 1'b1;
    wait_busy("areset_entry");
    repeat (5) step();
    #1 reset = 1'b1;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_esc", esc_level, 0);
    chk("areset_code", lock_code, 4'b1010);
    chk("areset_pulses", {core_relock, core_clear, prog_ok, prog_err}, 0);
    core_lockout = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (BASE * 8 + 4) step();
    chk("areset_no_clear", clear_cnt - c0, 0);
    chk("areset_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
